rat_restore_walker: RTL and testbench

//  Sequences rollback of the register alias table after a flush (mispredict/exception).

---
 rtl/rat_restore_walker.sv | 221 ++++++++++++++++++++++
 tb/tb_rat_restore_walker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_restore_walker.sv
`default_nettype none
// ============================================================================
//  Module   : rat_restore_walker
//  Purpose  : Rolls the register alias table back after a flush. It walks the
//             ROB entries younger than the flushing instruction, youngest
//             first and one per cycle, and replays each (new, old) physical
//             id pair into the RAT restore port. Rename stays stalled until
//             the walk completes.
//  Options  : RAT_RESTORE_WALKER_PERF_EN adds saturating performance counters
//             (perf_walk_count, perf_stall_cycles).
//  Revision : 1.0  initial release
// ============================================================================
module rat_restore_walker #(
    parameter int ROB_DEPTH        = 16,
    parameter int ROB_ID_WIDTH     = 4,
    parameter int PHY_REG_ID_WIDTH = 6
) (
    input  logic                        clk,
    input  logic                        rst,

    // Flush request from the commit stage
    input  logic                        flush_req,
    input  logic [ROB_ID_WIDTH-1:0]     flush_rob_id,
    input  logic [ROB_ID_WIDTH-1:0]     rob_tail_id,
    output logic                        flush_ack,

    // ROB read port (combinational read)
    output logic [ROB_ID_WIDTH-1:0]     rob_rd_id,
    input  logic                        rob_rd_has_dest,
    input  logic [PHY_REG_ID_WIDTH-1:0] rob_rd_new_phy_id,
    input  logic [PHY_REG_ID_WIDTH-1:0] rob_rd_old_phy_id,

    // RAT restore port
    output logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_new_phy_id,
    output logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_old_phy_id,
    output logic                        commit_rat_restore_map,

    // Pipeline control
    output logic                        rename_stall,
    output logic                        walk_done
`ifdef RAT_RESTORE_WALKER_PERF_EN
    ,
    output logic [31:0]                 perf_walk_count,
    output logic [31:0]                 perf_stall_cycles
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [ROB_ID_WIDTH-1:0] c_ID_ONE  = ROB_ID_WIDTH'(1);
    localparam logic [ROB_ID_WIDTH-1:0] c_ID_LAST = ROB_ID_WIDTH'(ROB_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t                        r_state;
    state_t                        w_state_nxt;

    logic [ROB_ID_WIDTH-1:0]       r_ptr;      // entry being read this cycle
    logic [ROB_ID_WIDTH-1:0]       r_end;      // flushing entry, never walked
    logic [PHY_REG_ID_WIDTH-1:0]   r_new_phy;
    logic [PHY_REG_ID_WIDTH-1:0]   r_old_phy;
    logic                          r_map;
    logic                          r_stall;
    logic                          r_done;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [ROB_ID_WIDTH-1:0]       w_ptr_init;  // youngest valid entry
    logic [ROB_ID_WIDTH-1:0]       w_ptr_dec;   // next-younger-to-older pointer
    logic                          w_accept;
    logic                          w_walk_empty;
    logic                          w_walk_last;

    // Derive the walk start point, pointer step and the end-of-walk tests
    always_comb begin
        w_ptr_init   = rob_tail_id - c_ID_ONE;
        // N == 0 exactly when the youngest live entry is the flushing one
        w_walk_empty = (w_ptr_init == flush_rob_id);
        // Explicit wrap keeps the pointer inside the ROB for any depth
        w_ptr_dec    = (r_ptr == '0) ? c_ID_LAST : (r_ptr - c_ID_ONE);
        w_walk_last  = (w_ptr_dec == r_end);
        w_accept     = (r_state == S_IDLE) && flush_req;
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    // Hold the walk state; an asynchronous reset aborts any walk in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and combinational outputs
    // ------------------------------------------------------------------------
    // Select the next state and drive the combinational handshake/read address
    always_comb begin
        w_state_nxt = r_state;
        flush_ack   = 1'b0;
        rob_rd_id   = '0;

        case (r_state)
            S_IDLE: begin
                flush_ack = flush_req;
                if (flush_req) begin
                    w_state_nxt = w_walk_empty ? S_DONE : S_WALK;
                end
            end

            S_WALK: begin
                rob_rd_id = r_ptr;
                if (w_walk_last) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Walk pointer and end marker
    // ------------------------------------------------------------------------
    // Load the pointer on accept and step it toward the flushing entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_end <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_init;
            r_end <= flush_rob_id;
        end else if (r_state == S_WALK) begin
            r_ptr <= w_ptr_dec;
        end
    end

    // ------------------------------------------------------------------------
    // RAT restore port
    // ------------------------------------------------------------------------
    // Latch the pair read this cycle; the strobe marks entries with a dest
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_new_phy <= '0;
            r_old_phy <= '0;
            r_map     <= 1'b0;
        end else if (r_state == S_WALK) begin
            r_new_phy <= rob_rd_new_phy_id;
            r_old_phy <= rob_rd_old_phy_id;
            r_map     <= rob_rd_has_dest;
        end else begin
            r_map     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stall and completion
    // ------------------------------------------------------------------------
    // Stall tracks the WALK/DONE states; done pulses on the edge leaving DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_stall <= (w_state_nxt == S_WALK) || (w_state_nxt == S_DONE);
            r_done  <= (r_state == S_DONE);
        end
    end

    assign commit_rat_restore_new_phy_id = r_new_phy;
    assign commit_rat_restore_old_phy_id = r_old_phy;
    assign commit_rat_restore_map        = r_map;
    assign rename_stall                  = r_stall;
    assign walk_done                     = r_done;

`ifdef RAT_RESTORE_WALKER_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------------
    logic [31:0] r_perf_walk;
    logic [31:0] r_perf_stall;

    // Count walked entries and stalled cycles, holding at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_walk  <= '0;
            r_perf_stall <= '0;
        end else begin
            if ((r_state == S_WALK) && (r_perf_walk != 32'hFFFF_FFFF)) begin
                r_perf_walk <= r_perf_walk + 32'd1;
            end
            if (r_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_walk_count   = r_perf_walk;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rat_restore_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rat_restore_walker
//  Purpose  : Directed self-checking bench for rat_restore_walker. The ROB is
//             a small table where entry i holds new id 16+i and old id 40+i.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rat_restore_walker;

    localparam int ROB_DEPTH        = 16;
    localparam int ROB_ID_WIDTH     = 4;
    localparam int PHY_REG_ID_WIDTH = 6;

    logic                        clk;
    logic                        rst;
    logic                        flush_req;
    logic [ROB_ID_WIDTH-1:0]     flush_rob_id;
    logic [ROB_ID_WIDTH-1:0]     rob_tail_id;
    logic                        flush_ack;
    logic [ROB_ID_WIDTH-1:0]     rob_rd_id;
    logic                        rob_rd_has_dest;
    logic [PHY_REG_ID_WIDTH-1:0] rob_rd_new_phy_id;
    logic [PHY_REG_ID_WIDTH-1:0] rob_rd_old_phy_id;
    logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_new_phy_id;
    logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_old_phy_id;
    logic                        commit_rat_restore_map;
    logic                        rename_stall;
    logic                        walk_done;
`ifdef RAT_RESTORE_WALKER_PERF_EN
    logic [31:0]                 perf_walk_count;
    logic [31:0]                 perf_stall_cycles;
`endif

    // ROB contents seen by the walker
    logic                        rob_has_dest [ROB_DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    rat_restore_walker #(
        .ROB_DEPTH        (ROB_DEPTH),
        .ROB_ID_WIDTH     (ROB_ID_WIDTH),
        .PHY_REG_ID_WIDTH (PHY_REG_ID_WIDTH)
    ) dut (
        .clk                           (clk),
        .rst                           (rst),
        .flush_req                     (flush_req),
        .flush_rob_id                  (flush_rob_id),
        .rob_tail_id                   (rob_tail_id),
        .flush_ack                     (flush_ack),
        .rob_rd_id                     (rob_rd_id),
        .rob_rd_has_dest               (rob_rd_has_dest),
        .rob_rd_new_phy_id             (rob_rd_new_phy_id),
        .rob_rd_old_phy_id             (rob_rd_old_phy_id),
        .commit_rat_restore_new_phy_id (commit_rat_restore_new_phy_id),
        .commit_rat_restore_old_phy_id (commit_rat_restore_old_phy_id),
        .commit_rat_restore_map        (commit_rat_restore_map),
        .rename_stall                  (rename_stall),
        .walk_done                     (walk_done)
`ifdef RAT_RESTORE_WALKER_PERF_EN
        ,
        .perf_walk_count               (perf_walk_count),
        .perf_stall_cycles             (perf_stall_cycles)
`endif
    );

    // Combinational ROB read port
    assign rob_rd_has_dest   = rob_has_dest[rob_rd_id];
    assign rob_rd_new_phy_id = PHY_REG_ID_WIDTH'(16) + PHY_REG_ID_WIDTH'(rob_rd_id);
    assign rob_rd_old_phy_id = PHY_REG_ID_WIDTH'(40) + PHY_REG_ID_WIDTH'(rob_rd_id);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check a restore strobe with its pair
    task automatic chk_strobe(input string tag, input int ent);
        chk({tag, " map"}, 32'(commit_rat_restore_map), 32'd1);
        chk({tag, " new"}, 32'(commit_rat_restore_new_phy_id), 32'(16 + ent));
        chk({tag, " old"}, 32'(commit_rat_restore_old_phy_id), 32'(40 + ent));
    endtask

    initial begin
        for (int i = 0; i < ROB_DEPTH; i++) rob_has_dest[i] = 1'b1;
        rst          = 1'b0;
        flush_req    = 1'b0;
        flush_rob_id = '0;
        rob_tail_id  = '0;

        // ---------------- 1: reset ----------------
        step();
        step();
        chk("rst map",   32'(commit_rat_restore_map), 32'd0);
        chk("rst stall", 32'(rename_stall), 32'd0);
        chk("rst done",  32'(walk_done), 32'd0);
        chk("rst rd_id", 32'(rob_rd_id), 32'd0);
        chk("rst newid", 32'(commit_rat_restore_new_phy_id), 32'd0);
        rst = 1'b1;
        step();
        chk("post-rst stall", 32'(rename_stall), 32'd0);
        chk("post-rst ack",   32'(flush_ack), 32'd0);

        // ---------------- 2: tail=5 flush=1, N=3 ----------------
        flush_req = 1'b1; rob_tail_id = 4'd5; flush_rob_id = 4'd1;
        #1;
        chk("t2 ack", 32'(flush_ack), 32'd1);
        step();                                    // E0
        flush_req = 1'b0;
        chk("t2 stall E0", 32'(rename_stall), 32'd1);
        chk("t2 rd E0",    32'(rob_rd_id), 32'd4);
        chk("t2 map E0",   32'(commit_rat_restore_map), 32'd0);
        step();                                    // E1
        chk_strobe("t2 k1", 4);
        chk("t2 rd E1", 32'(rob_rd_id), 32'd3);
        step();                                    // E2
        chk_strobe("t2 k2", 3);
        chk("t2 rd E2", 32'(rob_rd_id), 32'd2);
        step();                                    // E3
        chk_strobe("t2 k3", 2);
        chk("t2 stall E3", 32'(rename_stall), 32'd1);
        chk("t2 done E3",  32'(walk_done), 32'd0);
        chk("t2 rd E3",    32'(rob_rd_id), 32'd0);
        step();                                    // E4
        chk("t2 done E4",  32'(walk_done), 32'd1);
        chk("t2 map E4",   32'(commit_rat_restore_map), 32'd0);
        chk("t2 stall E4", 32'(rename_stall), 32'd0);
        step();
        chk("t2 done E5",  32'(walk_done), 32'd0);

        // ---------------- 3: tail=2 flush=13, wrap, N=4 ----------------
        flush_req = 1'b1; rob_tail_id = 4'd2; flush_rob_id = 4'd13;
        step();                                    // E0
        flush_req = 1'b0;
        chk("t3 rd E0", 32'(rob_rd_id), 32'd1);
        step();
        chk_strobe("t3 k1", 1);
        chk("t3 rd E1", 32'(rob_rd_id), 32'd0);
        step();
        chk_strobe("t3 k2", 0);
        chk("t3 rd E2", 32'(rob_rd_id), 32'd15);
        step();
        chk_strobe("t3 k3", 15);
        chk("t3 rd E3", 32'(rob_rd_id), 32'd14);
        step();
        chk_strobe("t3 k4", 14);
        chk("t3 done E4", 32'(walk_done), 32'd0);
        step();
        chk("t3 done E5", 32'(walk_done), 32'd1);
        chk("t3 map E5",  32'(commit_rat_restore_map), 32'd0);

        // ---------------- 4: tail=7 flush=6, N=0 ----------------
        step();
        flush_req = 1'b1; rob_tail_id = 4'd7; flush_rob_id = 4'd6;
        #1;
        chk("t4 ack", 32'(flush_ack), 32'd1);
        step();                                    // E0
        flush_req = 1'b0;
        chk("t4 stall E0", 32'(rename_stall), 32'd1);
        chk("t4 map E0",   32'(commit_rat_restore_map), 32'd0);
        chk("t4 done E0",  32'(walk_done), 32'd0);
        chk("t4 rd E0",    32'(rob_rd_id), 32'd0);
        step();                                    // E1
        chk("t4 done E1",  32'(walk_done), 32'd1);
        chk("t4 stall E1", 32'(rename_stall), 32'd0);
        chk("t4 map E1",   32'(commit_rat_restore_map), 32'd0);
        step();
        chk("t4 done E2",  32'(walk_done), 32'd0);

        // ---------------- 5: tail=9 flush=4, entry 7 no dest ----------------
        rob_has_dest[7] = 1'b0;
        flush_req = 1'b1; rob_tail_id = 4'd9; flush_rob_id = 4'd4;
        step();                                    // E0
        flush_req = 1'b0;
        step();
        chk_strobe("t5 k1", 8);
        step();
        chk("t5 map k2 nodest", 32'(commit_rat_restore_map), 32'd0);
        chk("t5 stall k2",      32'(rename_stall), 32'd1);
        step();
        chk_strobe("t5 k3", 6);
        step();
        chk_strobe("t5 k4", 5);
        chk("t5 done E4", 32'(walk_done), 32'd0);
        step();
        chk("t5 done E5", 32'(walk_done), 32'd1);
        rob_has_dest[7] = 1'b1;

        // ---------------- 6: flush during walk, reset mid-walk ----------------
        step();
        flush_req = 1'b1; rob_tail_id = 4'd5; flush_rob_id = 4'd0;
        step();                                    // E0, walking 4..1
        rob_tail_id = 4'd12; flush_rob_id = 4'd2;  // second request held high
        #1;
        chk("t6 no ack WALK", 32'(flush_ack), 32'd0);
        step();                                    // E1
        chk_strobe("t6 k1", 4);
        chk("t6 rd not restarted", 32'(rob_rd_id), 32'd3);
        chk("t6 no ack E1", 32'(flush_ack), 32'd0);
        flush_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6 rst map",   32'(commit_rat_restore_map), 32'd0);
        chk("t6 rst stall", 32'(rename_stall), 32'd0);
        chk("t6 rst rd",    32'(rob_rd_id), 32'd0);
        chk("t6 rst done",  32'(walk_done), 32'd0);
        step();
        rst = 1'b1;
        step();
        step();
        chk("t6 idle map",   32'(commit_rat_restore_map), 32'd0);
        chk("t6 idle stall", 32'(rename_stall), 32'd0);
        chk("t6 idle done",  32'(walk_done), 32'd0);
        flush_req = 1'b1; rob_tail_id = 4'd3; flush_rob_id = 4'd1;
        #1;
        chk("t6 ack after rst", 32'(flush_ack), 32'd1);
        step();
        flush_req = 1'b0;
        chk("t6 rd after rst", 32'(rob_rd_id), 32'd2);
        step();
        chk_strobe("t6 r k1", 2);
        step();
        chk("t6 r done", 32'(walk_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
